// File: rtl/jtag_master_if.sv
// Command/response and TAP-pin bundle between the host logic and jtag_master.
interface jtag_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, jtag_tdo,
    input  cmd_ready, rsp_valid, rsp_data, busy, jtag_tck, jtag_tms, jtag_tdi
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, jtag_tdo,
    output cmd_ready, rsp_valid, rsp_data, busy, jtag_tck, jtag_tms, jtag_tdi
  );
endinterface

// File: rtl/jtag_master.sv
// JTAG host sequencer: turns single-beat commands into TCK/TMS/TDI bit streams at clk/2
// and returns the TDO bits captured during the shift phase.
module jtag_master (
  input  logic         tck,
  input  logic         trst,
  jtag_master_if.slave bus
);
  typedef enum logic [2:0] {StReady, StHead, StShift, StTail, StDone} state_e;

  localparam logic [1:0] OpReset = 2'd0;
  localparam logic [1:0] OpIr    = 2'd1;
  localparam logic [1:0] OpDr    = 2'd2;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [1:0]  op_q;
  logic [4:0]  len_q;
  logic [31:0] data_q, rsp_q;
  logic        accept, active, last;
  logic [5:0]  last_cnt;
  logic [31:0] head_pat;

  assign accept = bus.cmd_valid && (state_q == StReady);
  assign active = (state_q == StHead) || (state_q == StShift) || (state_q == StTail);
  assign last   = (cnt_q == last_cnt);

  // Per-state bit count and head TMS pattern (bit i = TMS of head bit i)
  always_comb begin
    last_cnt = 6'd1;
    head_pat = 32'h0;
    case (state_q)
      StHead: begin
        case (op_q)
          OpReset: begin last_cnt = 6'd5; head_pat = 32'h1F; end
          OpIr:    begin last_cnt = 6'd3; head_pat = 32'h3;  end
          OpDr:    begin last_cnt = 6'd2; head_pat = 32'h1;  end
          default: last_cnt = {1'b0, len_q};
        endcase
      end
      StShift: last_cnt = {1'b0, len_q};
      default: last_cnt = 6'd1;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= StReady;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = active && !phase_q;
    cnt_d   = cnt_q;
    if (!active)                cnt_d = 6'd0;
    else if (phase_q)           cnt_d = last ? 6'd0 : cnt_q + 6'd1;
    case (state_q)
      StReady: if (accept) state_d = StHead;
      StHead: begin
        if (phase_q && last) state_d = (op_q == OpIr || op_q == OpDr) ? StShift : StDone;
      end
      StShift: if (phase_q && last) state_d = StTail;
      StTail:  if (phase_q && last) state_d = StDone;
      StDone:  state_d = StReady;
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      cnt_q   <= 6'd0;
      phase_q <= 1'b0;
      op_q    <= 2'd0;
      len_q   <= 5'd0;
      data_q  <= 32'h0;
      rsp_q   <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (accept) begin
        op_q   <= bus.cmd_op;
        len_q  <= bus.cmd_len;
        data_q <= bus.cmd_data;
        rsp_q  <= 32'h0;
      end else if (state_q == StShift && !phase_q) begin
        // This edge raises TCK: TDO holds what the TAP drove at the last fall
        rsp_q[cnt_q[4:0]] <= bus.jtag_tdo;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = (state_q == StReady);
    bus.busy      = (state_q != StReady);
    bus.rsp_valid = (state_q == StDone);
    bus.rsp_data  = rsp_q;
    bus.jtag_tck  = phase_q;
    bus.jtag_tms  = 1'b0;
    bus.jtag_tdi  = 1'b0;
    case (state_q)
      StHead:  bus.jtag_tms = head_pat[cnt_q[4:0]];
      StShift: begin
        bus.jtag_tms = last;
        bus.jtag_tdi = data_q[cnt_q[4:0]];
      end
      StTail:  bus.jtag_tms = (cnt_q == 6'd0);
      default: ;
    endcase
  end
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP with 2-bit IR (1: 8-bit scratch, 3: 32-bit scratch,
// else bypass), scoreboard of expected response data and latency.
module tb_jtag_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_master_if bus ();

  jtag_master u_dut (
    .tck  (clk),
    .trst (rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, overlap = 0;

  // TAP model
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int          tap_st = 0;
  logic [1:0]  ir = 2'd2, ir_sr = 2'd0;
  logic [31:0] dr_sr = 32'h0, scr32 = 32'h0, tms_hist = 32'h0;
  logic [7:0]  scr8 = 8'h0;
  int          pulses = 0, dirty = 0;

  initial bus.jtag_tdo = 1'b0;

  always @(posedge bus.jtag_tck) begin
    tms_hist = {tms_hist[30:0], bus.jtag_tms};
    pulses++;
    if (bus.jtag_tms || bus.jtag_tdi) dirty++;
    case (tap_st)
      0:  begin ir = 2'd2; scr32 = 32'h0; scr8 = 8'h0; end
      3:  dr_sr = (ir == 2'd3) ? scr32 : (ir == 2'd1) ? {24'h0, scr8} : 32'h0;
      4: begin
        if (ir == 2'd3)      dr_sr = {bus.jtag_tdi, dr_sr[31:1]};
        else if (ir == 2'd1) dr_sr[7:0] = {bus.jtag_tdi, dr_sr[7:1]};
        else                 dr_sr[0] = bus.jtag_tdi;
      end
      8: begin
        if (ir == 2'd3)      scr32 = dr_sr;
        else if (ir == 2'd1) scr8 = dr_sr[7:0];
      end
      10: ir_sr = 2'd0;
      11: ir_sr = {bus.jtag_tdi, ir_sr[1]};
      15: ir = ir_sr;
      default: ;
    endcase
    tap_st = bus.jtag_tms ? nxt1[tap_st] : nxt0[tap_st];
  end

  always @(negedge bus.jtag_tck)
    bus.jtag_tdo = (tap_st == 4) ? dr_sr[0] : (tap_st == 11) ? ir_sr[0] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: acceptance tracking and scoreboard pop on every response
  always @(negedge clk) begin
    if (bus.cmd_ready && bus.busy) overlap++;
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      acc_cyc = cyc;
      acc_cnt++;
    end
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%08h, required no response",
                 bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  // Called at posedge+1; n is the TCK bit count of the command
  task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] d,
                       input bit chk, input logic [31:0] exp, input int n);
    int w = 0;
    while (!bus.cmd_ready && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got cmd_ready=0, required 1 within 400 cycles");
      return;
    end
    if (chk) sb.push_back(exp_t'{exp, 2 * n + 1});
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(sb.size() == 0 && bus.cmd_ready) && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d pending responses, required 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
    check({tag, "_pins"}, 32'({bus.jtag_tck, bus.jtag_tms, bus.jtag_tdi}), 32'd0);
  endtask

  initial begin
    int a0, p0, d0, w;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = 5'd0;
    bus.cmd_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // TAP reset: TMS 1,1,1,1,1,0, 13 cycles to response
    issue(2'd0, 5'd0, 32'h0, 1'b1, 32'h0, 6);
    wait_idle();
    check("op0_tms_seq", 32'(tms_hist[5:0]), 32'(6'b111110));
    check("op0_tap_idle", 32'(tap_st), 32'd1);

    issue(2'd1, 5'd1, 32'h3, 1'b1, 32'h0, 8);
    wait_idle();
    check("ir_is_3", 32'(ir), 32'd3);

    issue(2'd2, 5'd31, 32'hDEADBEEF, 1'b1, 32'h0, 37);
    issue(2'd2, 5'd31, 32'h12345678, 1'b1, 32'hDEADBEEF, 37);
    issue(2'd1, 5'd1, 32'h1, 1'b1, 32'h0, 8);
    issue(2'd2, 5'd7, 32'hA5, 1'b1, 32'h0, 13);
    issue(2'd2, 5'd7, 32'h3C, 1'b1, 32'hA5, 13);
    wait_idle();
    check("idle_pins", 32'({bus.jtag_tck, bus.jtag_tms, bus.jtag_tdi}), 32'd0);

    // Idle clocks with cmd_valid held through busy
    a0 = acc_cnt;
    p0 = pulses;
    d0 = dirty;
    sb.push_back(exp_t'{32'h0, 9});
    bus.cmd_op    = 2'd3;
    bus.cmd_len   = 5'd3;
    bus.cmd_data  = 32'hFFFFFFFF;
    bus.cmd_valid = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (bus.busy && w < 100);
    bus.cmd_valid = 1'b0;
    check("op3_busy_bound", 32'(w < 100), 32'd1);
    wait_idle();
    check("op3_acceptances", 32'(acc_cnt - a0), 32'd1);
    check("op3_tck_pulses", 32'(pulses - p0), 32'd4);
    check("op3_tms_tdi_high", 32'(dirty - d0), 32'd0);

    // Abort a DR scan mid-shift
    issue(2'd1, 5'd1, 32'h3, 1'b1, 32'h0, 8);
    issue(2'd2, 5'd31, 32'hCAFEF00D, 1'b0, 32'h0, 37);
    repeat (30) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    issue(2'd0, 5'd0, 32'h0, 1'b1, 32'h0, 6);
    issue(2'd1, 5'd1, 32'h3, 1'b1, 32'h0, 8);
    issue(2'd2, 5'd31, 32'hCAFEF00D, 1'b1, 32'h0, 37);
    issue(2'd2, 5'd31, 32'h0, 1'b1, 32'hCAFEF00D, 37);
    wait_idle();

    check("ready_busy_overlap", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtag_master.md
# jtag_master

Command-driven JTAG host sequencer that turns single-beat commands into TCK/TMS/TDI waveforms for the on-chip `jtag` TAP and collects TDO. It divides the system clock by two to form TCK and walks the TAP through reset, run-test-idle, IR scans and DR scans of 1–32 bits. It returns captured scan-out data through a response pulse. It sits between the test/control logic and the TAP, and is the only driver of the TAP pins.

## Interface
- No parameters.
- `tck`  in  1  system clock; all logic on posedge.
- `trst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = idle clocks.
- `cmd_len`  in  5  scan or idle length minus one, so L = `cmd_len`+1 (1..32).
- `cmd_data`  in  32  scan-in bits, LSB first; bits ≥ L are ignored.
- `rsp_valid`  out  1  one-cycle pulse at command completion.
- `rsp_data`  out  32  captured TDO bits, right-aligned; bits ≥ L read 0.
- `busy`  out  1  command in progress.
- `jtag_tck`, `jtag_tms`, `jtag_tdi`  out  1 each  TAP pins.
- `jtag_tdo`  in  1  TAP scan-out.

## Operation
- Handshake:
  - A command is accepted on a posedge with `cmd_valid && cmd_ready`.
  - `cmd_op`, `cmd_len` and `cmd_data` are registered on acceptance.
  - `cmd_ready` = state READY. It is never high together with `busy`.
- TCK bit period is 2 clock cycles:
  - Low phase: `jtag_tck`=0. `jtag_tms` and `jtag_tdi` take the new bit.
  - High phase: `jtag_tck`=1. TMS and TDI are held.
  - TDO is sampled on the clock edge that raises `jtag_tck`, i.e. the value the TAP drove at the previous TCK fall.
- The master assumes the TAP is in Run-Test/Idle at command start. Software issues op 0 after any reset.
- TMS sequences (one entry per TCK, left to right); "shift" = L bits, TMS=0 except the last bit, which has TMS=1:
  - Op 0, reset: 1,1,1,1,1,0. N=6. TDI=0.
  - Op 1, IR scan: 1,1,0,0, shift, 1,0. N=L+6.
  - Op 2, DR scan: 1,0,0, shift, 1,0. N=L+5.
  - Op 3, idle: L×0. N=L. TDI=0.
- Scan data:
  - During shift bit k (k = 0..L-1), TDI = `cmd_data[k]`.
  - TDO sampled at that bit's rising edge is stored to `rsp_data[k]`.
  - Outside shift bits, TDI=0.
- States:
  - READY → HEAD (preamble TMS bits; skipped for ops 0/3, which use HEAD only as a TMS-pattern run).
  - HEAD → SHIFT → TAIL → DONE → READY.
  - A bit counter (6 bits) and a phase bit sequence each state.
- DONE:
  - `rsp_valid`=1 for one cycle; `rsp_data` is valid that cycle and is held until the next acceptance.
  - Ops 0 and 3 return `rsp_data`=0.
- Between commands: `jtag_tck`=0, `jtag_tms`=0, `jtag_tdi`=0, so the TAP stays in Idle.

## Timing
- Reset values (asserted asynchronously):
  - state READY, `cmd_ready`=1, `busy`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - `jtag_tck`=0, `jtag_tms`=0, `jtag_tdi`=0, all counters 0.
- Acceptance at edge 0:
  - Cycle 1 is the first TCK low phase. Cycles 1..2N carry the TCK bits, odd = low and even = high.
  - `busy`=1 in cycles 1..2N+1.
  - Cycle 2N+1: DONE, `rsp_valid`=1, `jtag_tck`=0.
  - Cycle 2N+2: `cmd_ready`=1. Back-to-back throughput is one command per 2N+2 cycles.
- `jtag_tck` never glitches; every high phase lasts exactly 1 clock cycle and every low phase at least 1.
- `cmd_valid` while busy is ignored (no acceptance, no side effects).
- `trst` mid-command:
  - Immediate abort to reset values; no `rsp_valid`.
  - TAP state is then undefined until an op 0.
- L=32 (`cmd_len`=31) shifts all 32 bits. The counter does not wrap early.

## Test plan
- After `trst` release, issue op 0 → `cmd_ready` low for cycles 1..13. TMS shows five 1-bits then one 0-bit. `rsp_valid` in cycle 13, `rsp_data`=0. TAP ends in IDLE.
- Op 1, `cmd_len`=1, `cmd_data`=2'b11 → N=8, `rsp_valid` in cycle 17, `rsp_data`=0 (NOP captured). TAP IR=3 (32-bit scratch) and ends in IDLE.
- Op 2 with L=32 and data 0xDEADBEEF, then op 2 with L=32 and data 0x12345678 → second `rsp_data`=0xDEADBEEF. Each command takes 75 cycles to `rsp_valid`.
- IR=1 (8-bit scratch); op 2 with L=8 and 0xA5; then op 2 with L=8 and 0x3C → second `rsp_data`=0x000000A5.
- Op 3, `cmd_len`=3 → 4 TCK pulses with TMS=0 and TDI=0, `rsp_valid` in cycle 9. `cmd_valid` held high during busy causes no second acceptance.
- `trst` pulse in the middle of a DR scan → outputs at reset values within the same cycle, no `rsp_valid`. A following op 0 plus the DR scan above completes correctly.
